wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, register data width; ADDR_W, default 3, register address width; LQ_DEPTH, default 2, load-return queue entries; STARVE_LIM, default 3, cycles a queued load may wait before preempting ALU.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- ld_valid  in  1  load return offered.
- ld_ready  out  1  load return accepted this cycle when high with ld_valid.
- ld_rd  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load data.
- rf_we  out  1  register file write enable.
- rf_ws  out  ADDR_W  register file write address.
- rf_wd  out  DATA_W  register file write data.
- lq_count  out  clog2(LQ_DEPTH+1)  current queue occupancy.
REQ-003 SHALL use one clock; reset is synchronous and active-low, ports named clk and rst_n.

Function
REQ-004 SHALL drive rf_we/rf_ws/rf_wd from registers; write lands one cycle after acceptance (latency 1).
REQ-005 SHALL accept a load into the tail of a FIFO of LQ_DEPTH entries when ld_valid && ld_ready; ld_ready = (lq_count < LQ_DEPTH) combinationally.
REQ-006 SHALL also accept a load when full if the head pops in the same cycle? No: ld_ready depends only on occupancy at cycle start; push-when-full never occurs.
REQ-007 SHALL select per cycle, in priority order: (a) queue head if starve counter == STARVE_LIM; (b) ALU if alu_valid; (c) queue head if non-empty; (d) no write (rf_we=0 next cycle).
REQ-008 SHALL drive alu_ready = !(starve counter == STARVE_LIM); ALU source holds alu_rd/alu_data while alu_valid && !alu_ready.
REQ-009 SHALL count starve cycles: increment (saturating at STARVE_LIM) each cycle the queue is non-empty and the head is not popped; clear on head pop or when queue empty.
REQ-010 SHALL bypass: load arriving into an empty queue with no ALU write that cycle is written the next cycle without occupying a queue slot for an extra cycle (push and pop same cycle; lq_count stays 0).
REQ-011 SHALL, on simultaneous push and pop with non-empty queue, keep lq_count unchanged and preserve FIFO order.
REQ-012 SHALL squash (invalidate, no write) any queued entry whose rd equals an accepted ALU rd in the same cycle; squashed entries pop without write at their turn (slot freed, starve counter cleared).
REQ-013 SHALL wrap read/write pointers modulo LQ_DEPTH.
REQ-014 SHALL write register 0 like any other register (no hard-wired zero).

Reset
REQ-015 SHALL, when rst_n low at a clock edge: rf_we=0, rf_ws=0, rf_wd=0, queue empty (lq_count=0, pointers 0, valid bits 0), starve counter 0.
REQ-016 SHALL ignore alu_valid/ld_valid in a reset cycle; queued data discarded on reset mid-operation.
REQ-017 SHALL present ld_ready=1 and alu_ready=1 the first cycle after reset release.

Structure
REQ-018 SHALL place DATA_W/ADDR_W defaults and the queue-entry struct (valid, rd, data) in shared package cpu_pkg.
REQ-019 SHALL implement the queue as sub-module wb_lq (FIFO with squash-by-address port); arbitration and starve counter stay in wb_stage.

Verification
REQ-020 ALU only: alu_valid, rd=3, data=0x1234 -> next cycle rf_we=1, ws=3, wd=0x1234; alu_ready=1 throughout.
REQ-021 Load bypass: empty queue, ld_valid rd=5 data=0xBEEF, no ALU -> next cycle write r5=0xBEEF, lq_count stays 0.
REQ-022 Queue full: ALU valid continuously, two loads (r1=0x0001, r2=0x0002) -> lq_count=2, ld_ready=0; after 3 waited cycles alu_ready=0, r1 written, then r2 after 3 more.
REQ-023 Squash: queued load rd=4, ALU write rd=4 accepted -> only ALU value reaches r4; lq_count decrements on squashed pop with no rf_we.
REQ-024 Reset mid-operation: queue 2 entries, rst_n=0 one cycle -> rf_we=0, lq_count=0, no queued write appears after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared writeback definitions: default register geometry and the load-return
// queue entry layout used by wb_stage and its queue.
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_ADDR_W = 3;

    // valid=0 marks a squashed (or empty) slot; occupancy is tracked by the count.
    typedef struct packed {
        logic                  valid;
        logic [CPU_ADDR_W-1:0] rd;
        logic [CPU_DATA_W-1:0] data;
    } lq_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/wb_lq.sv
// Load-return FIFO for the writeback stage. Entries whose destination matches
// the squash address are invalidated in place and still pop in order.
module wb_lq
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int LQ_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push_en,
    input  logic [ADDR_W-1:0]               push_rd,
    input  logic [DATA_W-1:0]               push_data,
    input  logic                            pop_en,
    input  logic                            squash_en,
    input  logic [ADDR_W-1:0]               squash_rd,
    output lq_entry_t                       head,
    output logic [$clog2(LQ_DEPTH+1)-1:0]   count
);

    localparam int PTR_W = ptr_w(LQ_DEPTH);
    localparam int CNT_W = $clog2(LQ_DEPTH + 1);

    lq_entry_t          mem_q [LQ_DEPTH];
    lq_entry_t          mem_d [LQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (squash_en) begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                if (mem_q[i].valid && (mem_q[i].rd == squash_rd)) begin
                    mem_d[i].valid = 1'b0;
                end
            end
        end

        if (pop_en) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d              = ptr_inc(rd_ptr_q);
        end

        // Push is applied last so a same-cycle arrival is never squashed.
        if (push_en) begin
            mem_d[wr_ptr_q] = '{valid: 1'b1, rd: push_rd, data: push_data};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end

        count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                mem_q[i].valid <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback arbiter: merges ALU results and queued load returns into a single
// registered register-file write port, with starvation preemption for loads.
module wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W     = CPU_DATA_W,
    parameter int ADDR_W     = CPU_ADDR_W,
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_LIM = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [ADDR_W-1:0]               alu_rd,
    input  logic [DATA_W-1:0]               alu_data,
    input  logic                            ld_valid,
    output logic                            ld_ready,
    input  logic [ADDR_W-1:0]               ld_rd,
    input  logic [DATA_W-1:0]               ld_data,
    output logic                            rf_we,
    output logic [ADDR_W-1:0]               rf_ws,
    output logic [DATA_W-1:0]               rf_wd,
    output logic [$clog2(LQ_DEPTH+1)-1:0]   lq_count
);

    localparam int CNT_W = $clog2(LQ_DEPTH + 1);
    localparam int SC_W  = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

    logic [SC_W-1:0]   sc_q, sc_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_ws_q, rf_ws_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;

    logic      lq_empty, starve, alu_acc, ld_acc, bypass, lq_push, lq_pop;
    lq_entry_t lq_head;

    wb_lq #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .LQ_DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_en   (lq_push),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .pop_en    (lq_pop),
        .squash_en (alu_acc),
        .squash_rd (alu_rd),
        .head      (lq_head),
        .count     (lq_count)
    );

    always_comb begin
        lq_empty  = (lq_count == '0);
        // A full starve counter implies a non-empty queue; the guard keeps
        // STARVE_LIM=0 from popping an empty queue.
        starve    = !lq_empty && (sc_q == SC_W'(STARVE_LIM));
        alu_ready = !starve;
        ld_ready  = (lq_count < CNT_W'(LQ_DEPTH));
        alu_acc   = alu_valid && alu_ready;
        ld_acc    = ld_valid && ld_ready;

        bypass  = 1'b0;
        lq_pop  = 1'b0;
        rf_we_d = 1'b0;
        rf_ws_d = rf_ws_q;
        rf_wd_d = rf_wd_q;

        if (starve || (!alu_valid && !lq_empty)) begin
            lq_pop  = 1'b1;
            rf_we_d = lq_head.valid;
            if (lq_head.valid) begin
                rf_ws_d = lq_head.rd;
                rf_wd_d = lq_head.data;
            end
        end else if (alu_valid) begin
            rf_we_d = 1'b1;
            rf_ws_d = alu_rd;
            rf_wd_d = alu_data;
        end else if (ld_acc) begin
            // Empty queue and idle ALU: write the load straight through.
            bypass  = 1'b1;
            rf_we_d = 1'b1;
            rf_ws_d = ld_rd;
            rf_wd_d = ld_data;
        end

        lq_push = ld_acc && !bypass;

        if (lq_empty || lq_pop) begin
            sc_d = '0;
        end else if (sc_q != SC_W'(STARVE_LIM)) begin
            sc_d = sc_q + 1'b1;
        end else begin
            sc_d = sc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sc_q    <= '0;
            rf_we_q <= 1'b0;
            rf_ws_q <= '0;
            rf_wd_q <= '0;
        end else begin
            sc_q    <= sc_d;
            rf_we_q <= rf_we_d;
            rf_ws_q <= rf_ws_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_ws = rf_ws_q;
    assign rf_wd = rf_wd_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by randomized traffic, all
// checked against a queue-based reference model of the writeback rules.
module tb_wb_stage;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 2;
    localparam int LIM   = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          ld_valid, ld_ready;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic          rf_we;
    logic [AW-1:0] rf_ws;
    logic [DW-1:0] rf_wd;
    logic [$clog2(DEPTH+1)-1:0] lq_count;

    wb_stage #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .LQ_DEPTH   (DEPTH),
        .STARVE_LIM (LIM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .rf_we     (rf_we),
        .rf_ws     (rf_ws),
        .rf_wd     (rf_wd),
        .lq_count  (lq_count)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_err = 0;
    string phase = "init";

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        bit            live;
    } ment_t;

    ment_t         mq[$];
    int            msc = 0;
    bit            m_alu_rdy, m_ld_rdy, m_alu_acc, m_ld_acc;
    logic          exp_we;
    logic [AW-1:0] exp_ws;
    logic [DW-1:0] exp_wd;
    bit            chk_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, expv);
        end
    endtask

    task automatic take_head(output bit wrote);
        ment_t e;
        e     = mq.pop_front();
        wrote = e.live;
        if (e.live) begin
            exp_ws = e.rd;
            exp_wd = e.data;
        end
    endtask

    // One cycle of the writeback rules, evaluated on the current inputs.
    task automatic model_cycle();
        int sz0;
        bit popped, wrote, bypassed;
        if (!rst_n) begin
            mq.delete();
            msc       = 0;
            exp_we    = 1'b0;
            exp_ws    = '0;
            exp_wd    = '0;
            chk_data  = 1'b1;
            m_alu_acc = 1'b0;
            m_ld_acc  = 1'b0;
            return;
        end
        sz0       = mq.size();
        m_alu_rdy = (msc != LIM);
        m_ld_rdy  = (sz0 < DEPTH);
        m_alu_acc = alu_valid && m_alu_rdy;
        m_ld_acc  = ld_valid && m_ld_rdy;
        popped = 0; wrote = 0; bypassed = 0;
        if (msc == LIM) begin
            take_head(wrote);
            popped = 1;
        end else if (alu_valid) begin
            wrote  = 1;
            exp_ws = alu_rd;
            exp_wd = alu_data;
        end else if (sz0 > 0) begin
            take_head(wrote);
            popped = 1;
        end else if (m_ld_acc) begin
            wrote    = 1;
            bypassed = 1;
            exp_ws   = ld_rd;
            exp_wd   = ld_data;
        end
        if (m_alu_acc) begin
            foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 0;
        end
        if (m_ld_acc && !bypassed) mq.push_back('{rd: ld_rd, data: ld_data, live: 1'b1});
        if (sz0 == 0 || popped) msc = 0;
        else if (msc < LIM) msc++;
        exp_we   = wrote;
        chk_data = wrote;
    endtask

    task automatic step();
        #1;
        model_cycle();
        if (rst_n) begin
            chk("alu_ready", alu_ready, m_alu_rdy);
            chk("ld_ready", ld_ready, m_ld_rdy);
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, exp_we);
        if (chk_data) begin
            chk("rf_ws", rf_ws, exp_ws);
            chk("rf_wd", rf_wd, exp_wd);
        end
        chk("lq_count", lq_count, mq.size());
    endtask

    task automatic drive(input bit av, input int ar, input int ad,
                         input bit lv, input int lr, input int ldd);
        alu_valid = av;
        alu_rd    = AW'(ar);
        alu_data  = DW'(ad);
        ld_valid  = lv;
        ld_rd     = AW'(lr);
        ld_data   = DW'(ldd);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1, 2, 'h5555, 1, 3, 'h6666);
        phase = "reset";
        step();
        step();
        chk("rst_we", rf_we, 0);
        chk("rst_ws", rf_ws, 0);
        chk("rst_wd", rf_wd, 0);

        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        phase = "release";
        #1;
        chk("rel_alu_ready", alu_ready, 1);
        chk("rel_ld_ready", ld_ready, 1);
        step();

        phase = "alu_only";
        drive(1, 3, 'h1234, 0, 0, 0);
        step();
        chk("alu_ws", rf_ws, 3);
        chk("alu_wd", rf_wd, 'h1234);
        drive(0, 0, 0, 0, 0, 0);
        step();

        phase = "bypass";
        drive(0, 0, 0, 1, 5, 'hBEEF);
        step();
        chk("byp_we", rf_we, 1);
        chk("byp_ws", rf_ws, 5);
        chk("byp_wd", rf_wd, 'hBEEF);
        chk("byp_cnt", lq_count, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();

        phase = "full_starve";
        drive(1, 6, 'h0600, 1, 1, 'h0001);
        step();
        drive(1, 6, 'h0600, 1, 2, 'h0002);
        step();
        chk("full_cnt", lq_count, 2);
        chk("full_ld_ready", ld_ready, 0);
        drive(1, 6, 'h0600, 0, 0, 0);
        step();
        step();
        chk("starve1_alu_ready", alu_ready, 0);
        step();
        chk("starve1_ws", rf_ws, 1);
        chk("starve1_wd", rf_wd, 'h0001);
        step();
        step();
        step();
        chk("starve2_alu_ready", alu_ready, 0);
        step();
        chk("starve2_ws", rf_ws, 2);
        chk("starve2_wd", rf_wd, 'h0002);
        chk("starve2_cnt", lq_count, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();

        phase = "squash";
        drive(1, 7, 'h0707, 1, 4, 'h4444);
        step();
        drive(1, 4, 'hAAAA, 0, 0, 0);
        step();
        chk("sq_alu_ws", rf_ws, 4);
        chk("sq_alu_wd", rf_wd, 'hAAAA);
        chk("sq_cnt_held", lq_count, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("sq_pop_we", rf_we, 0);
        chk("sq_pop_cnt", lq_count, 0);
        step();

        phase = "mid_reset";
        drive(1, 6, 'h0606, 1, 1, 'h1111);
        step();
        drive(1, 6, 'h0606, 1, 2, 'h2222);
        step();
        chk("mr_cnt_before", lq_count, 2);
        rst_n = 1'b0;
        step();
        chk("mr_we", rf_we, 0);
        chk("mr_cnt", lq_count, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mr_no_write", rf_we, 0);
        end

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            if (!alu_valid || m_alu_acc) begin
                alu_valid = ($urandom_range(0, 99) < 55);
                alu_rd    = AW'($urandom_range(0, 7));
                alu_data  = DW'($urandom);
            end
            if (!ld_valid || m_ld_acc) begin
                ld_valid = ($urandom_range(0, 99) < 45);
                ld_rd    = AW'($urandom_range(0, 7));
                ld_data  = DW'($urandom);
            end
            rst_n = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
